// File: rtl/gstmcu_pkg.sv
// Shared GST MCU definitions: register indices within the FF8200 video block
// and the default byte-address width.
package gstmcu_pkg;

  localparam int ADDR_W_DEF = 22;

  localparam logic [4:0] REG_BASE_HI  = 5'd0;
  localparam logic [4:0] REG_BASE_MID = 5'd1;
  localparam logic [4:0] REG_CNT_HI   = 5'd2;
  localparam logic [4:0] REG_CNT_MID  = 5'd3;
  localparam logic [4:0] REG_CNT_LO   = 5'd4;
  localparam logic [4:0] REG_BASE_LO  = 5'd6;
  localparam logic [4:0] REG_LINEWID  = 5'd7;

  function automatic logic is_cnt_reg(input logic [4:0] idx);
    return (idx == REG_CNT_HI) || (idx == REG_CNT_MID) || (idx == REG_CNT_LO);
  endfunction

endpackage

// File: rtl/video_addr_counter_if.sv
// Bus bundle between the video timing/CPU side and the video address counter.
interface video_addr_counter_if #(
    parameter int ADDR_W = 22
);
    // fetch is a one-clk slot strobe; vid_req is its combinational qualification
    // (fetch & vde & hde) and vid_addr is the word address valid in that same clk.
    logic              vsync;
    logic              vde;
    logic              hde;
    logic              fetch;
    logic              reg_we;
    logic [4:0]        reg_addr;
    logic [7:0]        reg_din;
    logic [7:0]        reg_dout;
    logic [ADDR_W-2:0] vid_addr;
    logic              vid_req;

    modport master (
        output vsync, vde, hde, fetch, reg_we, reg_addr, reg_din,
        input  reg_dout, vid_addr, vid_req
    );

    modport slave (
        input  vsync, vde, hde, fetch, reg_we, reg_addr, reg_din,
        output reg_dout, vid_addr, vid_req
    );

endinterface

// File: rtl/video_base_regs.sv
// CPU-visible video base and line-width registers plus the FF8200 read mux.
// Register bytes are byte-address views; storage is word-address (bit 0 dropped).
module video_base_regs
    import gstmcu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit STE    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_we_i,
    input  logic [4:0]        reg_addr_i,
    input  logic [7:0]        reg_din_i,
    input  logic [ADDR_W-2:0] cnt_i,
    output logic [ADDR_W-2:0] base_o,
    output logic [7:0]        linewid_o,
    output logic [7:0]        reg_dout_o
);

    // Width of the high byte actually backed by storage (ADDR_W in 17..24).
    localparam int HI_W = ADDR_W - 16;

    logic [ADDR_W-2:0] base_q, base_d;
    logic [7:0]        linewid_q, linewid_d;

    always_comb begin
        base_d    = base_q;
        linewid_d = linewid_q;
        if (reg_we_i) begin
            case (reg_addr_i)
                REG_BASE_HI:  base_d[ADDR_W-2:15] = reg_din_i[HI_W-1:0];
                REG_BASE_MID: base_d[14:7]        = reg_din_i;
                REG_BASE_LO:  if (STE) base_d[6:0] = reg_din_i[7:1];
                REG_LINEWID:  if (STE) linewid_d   = reg_din_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            linewid_q <= '0;
        end else begin
            base_q    <= base_d;
            linewid_q <= linewid_d;
        end
    end

    // Plain ST keeps base lo and linewid at zero, so those reads fall out as 0x00.
    always_comb begin
        reg_dout_o = 8'h00;
        case (reg_addr_i)
            REG_BASE_HI:  reg_dout_o = 8'(base_q[ADDR_W-2:15]);
            REG_BASE_MID: reg_dout_o = base_q[14:7];
            REG_CNT_HI:   reg_dout_o = 8'(cnt_i[ADDR_W-2:15]);
            REG_CNT_MID:  reg_dout_o = cnt_i[14:7];
            REG_CNT_LO:   reg_dout_o = {cnt_i[6:0], 1'b0};
            REG_BASE_LO:  reg_dout_o = {base_q[6:0], 1'b0};
            REG_LINEWID:  reg_dout_o = linewid_q;
            default:      reg_dout_o = 8'h00;
        endcase
    end

    assign base_o    = base_q;
    assign linewid_o = linewid_q;

endmodule

// File: rtl/video_addr_counter.sv
// Shifter-side video word-address counter: reload at vsync, +1 per active fetch,
// +linewid at each line end, CPU byte writes to the counter on STE.
module video_addr_counter
    import gstmcu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit STE    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    video_addr_counter_if.slave  bus
);

    localparam int CW   = ADDR_W - 1;
    localparam int HI_W = ADDR_W - 16;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          vsync_q;
    logic          hde_q;
    logic          hde_fall_q, hde_fall_d;
    logic [CW-1:0] base;
    logic [7:0]    linewid;
    logic          vid_req;
    logic          vsync_rise;
    logic          cnt_wr;

    video_base_regs #(
        .ADDR_W (ADDR_W),
        .STE    (STE)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .reg_we_i   (bus.reg_we),
        .reg_addr_i (bus.reg_addr),
        .reg_din_i  (bus.reg_din),
        .cnt_i      (cnt_q),
        .base_o     (base),
        .linewid_o  (linewid),
        .reg_dout_o (bus.reg_dout)
    );

    assign vid_req    = bus.fetch & bus.vde & bus.hde;
    assign vsync_rise = bus.vsync & ~vsync_q;
    assign cnt_wr     = STE && bus.reg_we && is_cnt_reg(bus.reg_addr);
    // Line end is flagged one clk after hde is seen low, so it can coincide with a
    // fetch in the following clk and both add in together.
    assign hde_fall_d = hde_q & ~bus.hde & bus.vde;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_wr) begin
            case (bus.reg_addr)
                REG_CNT_HI:  cnt_d[CW-1:15] = bus.reg_din[HI_W-1:0];
                REG_CNT_MID: cnt_d[14:7]    = bus.reg_din;
                REG_CNT_LO:  cnt_d[6:0]     = bus.reg_din[7:1];
                default: ;
            endcase
        end else if (vsync_rise) begin
            cnt_d = base;
        end else begin
            cnt_d = cnt_q + CW'(vid_req) + (hde_fall_q ? CW'(linewid) : CW'(0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            vsync_q    <= 1'b0;
            hde_q      <= 1'b0;
            hde_fall_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            vsync_q    <= bus.vsync;
            hde_q      <= bus.hde;
            hde_fall_q <= hde_fall_d;
        end
    end

    assign bus.vid_addr = cnt_q;
    assign bus.vid_req  = vid_req;

endmodule
